sp_link_sync_ctrl: RTL and testbench

//  Byte-lock controller sequencing the serial-to-parallel deserializer of the PCIe PHY receive path.

---
 rtl/sp_link_sync_ctrl.sv | 154 +++++++++++++++
 tb/tb_sp_link_sync_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sp_link_sync_ctrl.sv
// Byte-lock controller for the PCIe PHY receive deserializer: hunts for comma alignment,
// requests bit-slips when none is found, and forwards data bytes once the lane is locked.
module sp_link_sync_ctrl #(
    parameter logic [7:0] COMMA_CHAR   = 8'hBC,
    parameter int         SYNC_COUNT   = 4,
    parameter int         SLIP_TIMEOUT = 16,
    parameter int         SLIP_SETTLE  = 2,
    parameter int         ERR_LIMIT    = 3
) (
    input  logic       clk_4f,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] byte_in,
    input  logic       byte_strobe,
    input  logic       sym_err,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active,
    output logic       slip,
    output logic [1:0] state
);

    localparam int CW = $clog2(SYNC_COUNT + 1);
    localparam int BW = $clog2(SLIP_TIMEOUT + 1);
    localparam int SW = (SLIP_SETTLE < 1) ? 1 : $clog2(SLIP_SETTLE + 1);
    localparam int EW = $clog2(ERR_LIMIT + 1);

    localparam logic [CW-1:0] SYNC_L   = CW'(SYNC_COUNT);
    localparam logic [BW-1:0] TIMEOUT_L = BW'(SLIP_TIMEOUT);
    localparam logic [SW-1:0] SETTLE_L = SW'(SLIP_SETTLE);
    localparam logic [EW-1:0] ERR_L    = EW'(ERR_LIMIT);
    localparam logic [CW-1:0] C_ONE    = CW'(1);
    localparam logic [BW-1:0] B_ONE    = BW'(1);
    localparam logic [SW-1:0] S_ONE    = SW'(1);
    localparam logic [EW-1:0] E_ONE    = EW'(1);

    typedef enum logic [1:0] {
        SEARCH    = 2'd0,
        COUNT     = 2'd1,
        ACTIVE    = 2'd2,
        SLIP_WAIT = 2'd3
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   comma_cnt;
    logic [BW-1:0]   byte_cnt;
    logic [SW-1:0]   settle_cnt;
    logic [EW-1:0]   err_cnt;

    logic [CW-1:0]   comma_inc;
    logic [BW-1:0]   byte_inc;
    logic [SW-1:0]   settle_inc;
    logic [EW-1:0]   err_inc;
    logic            is_comma;

    // Saturating increments: a counter parked at its limit never wraps.
    assign comma_inc  = (comma_cnt  == SYNC_L)    ? comma_cnt  : comma_cnt  + C_ONE;
    assign byte_inc   = (byte_cnt   == TIMEOUT_L) ? byte_cnt   : byte_cnt   + B_ONE;
    assign settle_inc = (settle_cnt >= SETTLE_L)  ? settle_cnt : settle_cnt + S_ONE;
    assign err_inc    = (err_cnt    == ERR_L)     ? err_cnt    : err_cnt    + E_ONE;
    assign is_comma   = (byte_in == COMMA_CHAR);
    assign state      = state_q;

    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) begin
            state_q    <= SEARCH;
            comma_cnt  <= '0;
            byte_cnt   <= '0;
            settle_cnt <= '0;
            err_cnt    <= '0;
            data_out   <= '0;
            valid_out  <= 1'b0;
            active     <= 1'b0;
            slip       <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            slip      <= 1'b0;
            if (!enable) begin
                state_q    <= SEARCH;
                comma_cnt  <= '0;
                byte_cnt   <= '0;
                settle_cnt <= '0;
                err_cnt    <= '0;
                active     <= 1'b0;
            end else if (byte_strobe) begin
                case (state_q)
                    SEARCH: begin
                        if (is_comma) begin
                            byte_cnt  <= '0;
                            comma_cnt <= C_ONE;
                            if (SYNC_COUNT <= 1) begin
                                state_q   <= ACTIVE;
                                active    <= 1'b1;
                                err_cnt   <= '0;
                                comma_cnt <= '0;
                            end else begin
                                state_q <= COUNT;
                            end
                        end else if (byte_inc == TIMEOUT_L) begin
                            slip       <= 1'b1;
                            state_q    <= SLIP_WAIT;
                            byte_cnt   <= '0;
                            settle_cnt <= '0;
                        end else begin
                            byte_cnt <= byte_inc;
                        end
                    end
                    COUNT: begin
                        if (!is_comma) begin
                            state_q   <= SEARCH;
                            comma_cnt <= '0;
                            byte_cnt  <= B_ONE;
                        end else if (comma_inc == SYNC_L) begin
                            state_q   <= ACTIVE;
                            active    <= 1'b1;
                            err_cnt   <= '0;
                            comma_cnt <= '0;
                        end else begin
                            comma_cnt <= comma_inc;
                        end
                    end
                    SLIP_WAIT: begin
                        // Bytes here are still misaligned; even commas are discarded.
                        if (settle_inc >= SETTLE_L) begin
                            state_q    <= SEARCH;
                            settle_cnt <= '0;
                        end else begin
                            settle_cnt <= settle_inc;
                        end
                    end
                    ACTIVE: begin
                        if (sym_err) begin
                            if (err_inc == ERR_L) begin
                                state_q <= SEARCH;
                                active  <= 1'b0;
                                err_cnt <= '0;
                            end else begin
                                err_cnt <= err_inc;
                            end
                        end else begin
                            err_cnt <= '0;
                            if (!is_comma) begin
                                data_out  <= byte_in;
                                valid_out <= 1'b1;
                            end
                        end
                    end
                    default: state_q <= SEARCH;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sp_link_sync_ctrl.sv
// Self-checking bench for sp_link_sync_ctrl: forwarded bytes are predicted into a queue
// and matched against valid_out pulses; lock/slip behaviour is checked after each strobe.
module tb_sp_link_sync_ctrl;

    localparam logic [7:0] COMMA = 8'hBC;
    localparam logic [1:0] S_SEARCH = 2'd0, S_COUNT = 2'd1, S_ACTIVE = 2'd2, S_SLIP_WAIT = 2'd3;

    logic       clk_4f = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic [7:0] byte_in = '0;
    logic       byte_strobe = 1'b0;
    logic       sym_err = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;
    logic       slip;
    logic [1:0] state;

    logic [7:0] exp_q[$];
    logic [7:0] last_fwd = '0;
    int         checks = 0;
    int         failures = 0;
    int         slip_seen = 0;
    int         valid_seen = 0;

    sp_link_sync_ctrl dut (
        .clk_4f(clk_4f), .reset(reset), .enable(enable), .byte_in(byte_in),
        .byte_strobe(byte_strobe), .sym_err(sym_err), .data_out(data_out),
        .valid_out(valid_out), .active(active), .slip(slip), .state(state)
    );

    always #5 clk_4f = ~clk_4f;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic e);
        @(negedge clk_4f);
        byte_in = b;
        sym_err = e;
        byte_strobe = 1'b1;
        @(posedge clk_4f);
        #1;
        byte_strobe = 1'b0;
        sym_err = 1'b0;
    endtask

    // Data byte the DUT must forward once locked.
    task automatic send_fwd(input logic [7:0] b);
        exp_q.push_back(b);
        last_fwd = b;
        send(b, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(posedge clk_4f);
        #1;
    endtask

    task automatic do_reset(input string tag);
        #2 reset = 1'b1;
        #1;
        chk({tag, "_state"}, 32'(state), 32'(S_SEARCH));
        chk({tag, "_active"}, 32'(active), 0);
        chk({tag, "_slip"}, 32'(slip), 0);
        chk({tag, "_valid"}, 32'(valid_out), 0);
        chk({tag, "_data"}, 32'(data_out), 0);
        last_fwd = '0;
        @(negedge clk_4f);
        reset = 1'b0;
    endtask

    task automatic lock(input string tag);
        for (int i = 0; i < 3; i++) send(COMMA, 1'b0);
        chk({tag, "_count"}, 32'(state), 32'(S_COUNT));
        chk({tag, "_not_yet"}, 32'(active), 0);
        send(COMMA, 1'b0);
        chk({tag, "_state"}, 32'(state), 32'(S_ACTIVE));
        chk({tag, "_active"}, 32'(active), 1);
    endtask

    always @(negedge clk_4f) begin
        if (slip) slip_seen++;
        if (valid_out) begin
            valid_seen++;
            if (exp_q.size() == 0) chk("unexpected_valid", 1, 0);
            else chk("data_out", 32'(data_out), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        logic [7:0] rb;
        int exp_valid;
        do_reset("rst0");

        // 1: basic lock then one data byte
        lock("t1");
        send_fwd(8'hAA);
        chk("t1_valid", 32'(valid_out), 1);
        idle(1);
        chk("t1_valid_pulse", 32'(valid_out), 0);
        chk("t1_data_hold", 32'(data_out), 32'hAA);

        // 2: broken comma run restarts the count; idle cycles hold the count
        do_reset("rst2");
        for (int i = 0; i < 3; i++) send(COMMA, 1'b0);
        send(8'h55, 1'b0);
        chk("t2_back_search", 32'(state), 32'(S_SEARCH));
        send(COMMA, 1'b0);
        send(COMMA, 1'b0);
        idle(3);
        chk("t2_hold_count", 32'(state), 32'(S_COUNT));
        send(COMMA, 1'b0);
        chk("t2_three", 32'(active), 0);
        send(COMMA, 1'b0);
        chk("t2_locked", 32'(state), 32'(S_ACTIVE));

        // 3: slip after timeout, settle strobes discarded
        do_reset("rst3");
        for (int i = 0; i < 15; i++) send(8'h00, 1'b0);
        chk("t3_no_slip_15", 32'(slip), 0);
        chk("t3_search_15", 32'(state), 32'(S_SEARCH));
        send(8'h00, 1'b0);
        chk("t3_slip", 32'(slip), 1);
        chk("t3_slip_wait", 32'(state), 32'(S_SLIP_WAIT));
        send(COMMA, 1'b0);
        chk("t3_slip_pulse", 32'(slip), 0);
        chk("t3_settle1", 32'(state), 32'(S_SLIP_WAIT));
        send(COMMA, 1'b0);
        chk("t3_settle2", 32'(state), 32'(S_SEARCH));
        send(COMMA, 1'b0);
        chk("t3_count", 32'(state), 32'(S_COUNT));
        chk("t3_slip_count", 32'(slip_seen), 1);

        // reset while a slip pulse is pending drops it at once
        do_reset("rst3b");
        for (int i = 0; i < 16; i++) send(8'h3C, 1'b0);
        chk("t3b_slip", 32'(slip), 1);
        reset = 1'b1;
        #1;
        chk("t3b_slip_dropped", 32'(slip), 0);
        chk("t3b_state", 32'(state), 32'(S_SEARCH));
        @(negedge clk_4f);
        reset = 1'b0;

        // 4: symbol-error tolerance and loss of lock
        lock("t4");
        send(8'h11, 1'b1);
        send(8'h12, 1'b1);
        chk("t4_two_err", 32'(state), 32'(S_ACTIVE));
        send_fwd(8'hBB);
        send(8'h13, 1'b1);
        send(8'h14, 1'b1);
        chk("t4_still_active", 32'(active), 1);
        send(COMMA, 1'b1);
        chk("t4_third_err", 32'(state), 32'(S_SEARCH));
        chk("t4_unlock", 32'(active), 0);
        chk("t4_data_hold", 32'(data_out), 32'hBB);

        // 5: commas are idles, not forwarded
        lock("t5");
        send(COMMA, 1'b0);
        send_fwd(8'hFF);
        send(COMMA, 1'b0);
        chk("t5_comma_no_valid", 32'(valid_out), 0);
        send_fwd(8'h00);
        chk("t5_data", 32'(data_out), 0);

        // random data stream while locked
        for (int i = 0; i < 40; i++) begin
            rb = 8'($urandom_range(0, 255));
            if (i % 7 == 3) rb = COMMA;
            if (rb == COMMA) send(rb, 1'b0);
            else send_fwd(rb);
        end
        chk("rand_active", 32'(active), 1);

        // 6: async reset mid-ACTIVE, then enable=0 mid-COUNT
        @(negedge clk_4f);
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_active", 32'(active), 0);
        chk("t6_rst_state", 32'(state), 32'(S_SEARCH));
        chk("t6_rst_data", 32'(data_out), 0);
        last_fwd = '0;
        @(negedge clk_4f);
        reset = 1'b0;
        send(COMMA, 1'b0);
        send(COMMA, 1'b0);
        chk("t6_count", 32'(state), 32'(S_COUNT));
        enable = 1'b0;
        send(COMMA, 1'b0);
        chk("t6_dis_state", 32'(state), 32'(S_SEARCH));
        chk("t6_dis_data", 32'(data_out), 32'(last_fwd));
        enable = 1'b1;
        lock("t6_relock");
        send_fwd(8'h5A);
        idle(2);

        exp_valid = valid_seen + exp_q.size();
        chk("queue_empty", 32'(exp_q.size()), 0);
        chk("valid_total", 32'(valid_seen), 32'(exp_valid));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
